// File: rtl/inv_cipher_ctrl_pkg.sv
// Shared types for the inverse-cipher round controller: datapath modes,
// controller states and the AES-128 round count.
package inv_cipher_ctrl_pkg;

   localparam int NR_AES128 = 10;

   typedef enum logic [1:0] {
      ARK_ONLY = 2'd0,
      FULL     = 2'd1,
      FINAL    = 2'd2
   } mode_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ROUND = 3'd2,
      LAST  = 3'd3,
      HOLD  = 3'd4
   } state_e;

endpackage

// File: rtl/inv_cipher_ctrl.sv
// Round sequencer for an iterative AES inverse cipher: walks key indices NR..0,
// stalls on missing round keys and holds the plaintext until it is consumed.
module inv_cipher_ctrl
   import inv_cipher_ctrl_pkg::*;
#(
   parameter int NR = NR_AES128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       key_valid,
   input  logic       out_ready,
   output logic       out_valid,
   output logic       load_en,
   output logic       step_en,
   output logic [1:0] mode,
   output logic [3:0] key_idx,
   output logic       busy
);

   localparam logic [3:0] NR_IDX      = 4'(NR);
   localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

   state_e     r_state;
   logic [3:0] r_cnt;

   logic       w_in_ready;
   logic       w_load;
   logic       w_active;
   mode_e      w_mode;
   logic [3:0] w_key_idx;

   assign w_in_ready = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
   assign w_load     = in_valid && w_in_ready && !rst;

   // State and round counter; a low key_valid freezes both in the stepping states
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_load) r_state <= INIT;
               else        r_state <= IDLE;
            end
            INIT: begin
               if (key_valid) begin
                  if (NR > 1) begin
                     r_state <= ROUND;
                     r_cnt   <= FIRST_ROUND;
                  end else begin
                     r_state <= LAST;
                     r_cnt   <= 4'd0;
                  end
               end
            end
            ROUND: begin
               // The <= guard keeps a corrupted zero count from wrapping to 15
               if (key_valid) begin
                  if (r_cnt <= 4'd1) begin
                     r_state <= LAST;
                     r_cnt   <= 4'd0;
                  end else begin
                     r_cnt   <= r_cnt - 4'd1;
                  end
               end
            end
            LAST: begin
               if (key_valid) r_state <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  if (in_valid) r_state <= INIT;
                  else          r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Moore decode of the datapath controls from the registered state
   always_comb begin
      w_mode    = ARK_ONLY;
      w_key_idx = 4'd0;
      w_active  = 1'b0;
      case (r_state)
         INIT: begin
            w_mode    = ARK_ONLY;
            w_key_idx = NR_IDX;
            w_active  = 1'b1;
         end
         ROUND: begin
            w_mode    = FULL;
            w_key_idx = r_cnt;
            w_active  = 1'b1;
         end
         LAST: begin
            w_mode    = FINAL;
            w_key_idx = 4'd0;
            w_active  = 1'b1;
         end
         default: begin
            w_mode    = ARK_ONLY;
            w_key_idx = 4'd0;
            w_active  = 1'b0;
         end
      endcase
   end

   assign in_ready  = w_in_ready;
   assign load_en   = w_load;
   assign step_en   = w_active && key_valid;
   assign mode      = w_mode;
   assign key_idx   = w_key_idx;
   assign out_valid = (r_state == HOLD);
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Self-checking bench for inv_cipher_ctrl: scenario tasks check timing inline,
// a scoreboard checks the key index / mode sequence of every step.
module tb_inv_cipher_ctrl;

   localparam int NR = 10;
   localparam logic [1:0] M_ARK   = 2'd0;
   localparam logic [1:0] M_FULL  = 2'd1;
   localparam logic [1:0] M_FINAL = 2'd2;

   typedef struct packed {
      logic [3:0] k;
      logic [1:0] m;
   } step_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       key_valid;
   logic       out_ready;
   logic       out_valid;
   logic       load_en;
   logic       step_en;
   logic [1:0] mode;
   logic [3:0] key_idx;
   logic       busy;

   int    total = 0;
   int    bad   = 0;
   step_t exp_q[$];

   inv_cipher_ctrl #(.NR(NR)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .key_valid(key_valid), .out_ready(out_ready), .out_valid(out_valid),
      .load_en(load_en), .step_en(step_en), .mode(mode), .key_idx(key_idx),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: a load queues NR+1 expected steps, every step pops one
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid) begin
            total++;
            if (exp_q.size() != 0) begin
               bad++;
               $display("FAIL sb_done: pending steps %0d want 0", exp_q.size());
            end
         end
         if (step_en) begin
            total++;
            if (load_en !== 1'b0) begin
               bad++;
               $display("FAIL sb_overlap: load_en %b with step_en, want 0", load_en);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra_step: key_idx %0d mode %0d, want no step", key_idx, mode);
            end else begin
               step_t s;
               s = exp_q.pop_front();
               if (key_idx !== s.k || mode !== s.m) begin
                  bad++;
                  $display("FAIL sb_step: key_idx %0d mode %0d, want key_idx %0d mode %0d",
                           key_idx, mode, s.k, s.m);
               end
            end
         end
         if (load_en) begin
            for (int r = NR; r >= 0; r--) begin
               step_t s;
               s.k = 4'(r);
               s.m = (r == NR) ? M_ARK : ((r == 0) ? M_FINAL : M_FULL);
               exp_q.push_back(s);
            end
         end
      end
   end

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (in_ready  !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (load_en   !== 1'b0) begin bad++; $display("FAIL rst_load_en: got %b want 0", load_en); end
      total++; if (step_en   !== 1'b0) begin bad++; $display("FAIL rst_step_en: got %b want 0", step_en); end
      total++; if (key_idx   !== 4'd0) begin bad++; $display("FAIL rst_key_idx: got %0d want 0", key_idx); end
      total++; if (mode      !== M_ARK) begin bad++; $display("FAIL rst_mode: got %0d want 0", mode); end
      total++; if (busy      !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      total++; if (load_en !== 1'b1) begin bad++; $display("FAIL single_load: got %b want 1", load_en); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 0; e <= NR + 1; e++) begin
         @(negedge clk);
         total++;
         if (out_valid !== (e == NR + 1)) begin
            bad++; $display("FAIL single_out_valid: edge %0d got %b want %b", e, out_valid, (e == NR + 1));
         end
         total++;
         if (step_en !== (e <= NR)) begin
            bad++; $display("FAIL single_step_en: edge %0d got %b want %b", e, step_en, (e <= NR));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL single_idle: busy %b out_valid %b in_ready %b want 0 0 1", busy, out_valid, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 0; e <= NR + 4; e++) begin
         key_valid = !(e >= 5 && e <= 7);
         @(negedge clk);
         total++;
         if (out_valid !== (e == NR + 4)) begin
            bad++; $display("FAIL stall_out_valid: edge %0d got %b want %b", e, out_valid, (e == NR + 4));
         end
         total++;
         if (step_en !== (e <= NR + 3 && !(e >= 5 && e <= 7))) begin
            bad++; $display("FAIL stall_step_en: edge %0d got %b", e, step_en);
         end
         if (e >= 5 && e <= 7) begin
            total++;
            if (key_idx !== 4'd5) begin
               bad++; $display("FAIL stall_key_idx: edge %0d got %0d want 5", e, key_idx);
            end
         end
         @(posedge clk); #1;
      end
      key_valid = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle: busy %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold;
      in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 0; e <= NR + 5; e++) begin
         out_ready = !(e >= NR + 1 && e <= NR + 4);
         @(negedge clk);
         total++;
         if (out_valid !== (e >= NR + 1)) begin
            bad++; $display("FAIL hold_out_valid: edge %0d got %b want %b", e, out_valid, (e >= NR + 1));
         end
         if (e >= NR + 1 && e <= NR + 4) begin
            total++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
               bad++; $display("FAIL hold_stalled: edge %0d in_ready %b busy %b want 0 1", e, in_ready, busy);
            end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL hold_release: busy %b out_valid %b want 0 0", busy, out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      for (int e = 0; e <= 2 * NR + 3; e++) begin
         in_valid = (e == NR + 1);
         @(negedge clk);
         total++;
         if (out_valid !== (e == NR + 1 || e == 2 * NR + 3)) begin
            bad++; $display("FAIL b2b_out_valid: edge %0d got %b", e, out_valid);
         end
         total++;
         if (load_en !== (e == NR + 1)) begin
            bad++; $display("FAIL b2b_load_en: edge %0d got %b want %b", e, load_en, (e == NR + 1));
         end
         total++;
         if (step_en !== (e <= NR || (e >= NR + 2 && e <= 2 * NR + 2))) begin
            bad++; $display("FAIL b2b_step_en: edge %0d got %b", e, step_en);
         end
         if (e == NR + 2) begin
            total++;
            if (key_idx !== 4'(NR) || mode !== M_ARK) begin
               bad++; $display("FAIL b2b_init: key_idx %0d mode %0d want %0d 0", key_idx, mode, NR);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: busy %b want 0", busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++; if (key_idx !== 4'd3) begin bad++; $display("FAIL mid_key_idx: got %0d want 3", key_idx); end
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || step_en !== 1'b0 || key_idx !== 4'd0 || mode !== M_ARK) begin
         bad++; $display("FAIL mid_async: busy %b step_en %b key_idx %0d mode %0d want 0 0 0 0",
                         busy, step_en, key_idx, mode);
      end
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL mid_async_hs: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int e = 0; e < NR + 3; e++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_aborted: cycle %0d out_valid %b busy %b want 0 0", e, out_valid, busy);
         end
         @(posedge clk); #1;
      end
      test_single();
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL sb_leftover: pending steps %0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
